pll_lock_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 25 ++
 rtl/sync_ff.sv | 19 +
 rtl/pll_lock_supervisor.sv | 129 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
// The state encoding is fixed at 3 bits so other blocks can decode it.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam int DEF_SYNC_STAGES         = 2;
    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 4096;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 270000;
    localparam int DEF_MAX_RETRIES         = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Reset-free multi-flop synchronizer for a single asynchronous bit.
// Usable for any slow level signal crossing into the clk domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Brings up a PLL from the reference clock: pulses its reset, debounces LOCK,
// retries on timeout and releases a synchronous system reset once stable.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               lock_i,
    output logic                               pll_reset_o,
    output logic                               sys_reset_o,
    output logic                               locked_o,
    output logic                               fail_o,
    output logic                               lock_lost_o,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count_o
);

    localparam int CNT_MAX = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       outs;
    logic             lock_s;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk(clk),
        .d  (lock_i),
        .q  (lock_s)
    );

    // {pll_reset, sys_reset, locked, fail} presented while in state s.
    function automatic logic [3:0] outs_for(input state_t s);
        case (s)
            PLL_RST:   return 4'b1100;
            WAIT_LOCK: return 4'b0100;
            STABLE:    return 4'b0100;
            RUN:       return 4'b0010;
            default:   return 4'b1101;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_W'(CNT_MAX)) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= PLL_RST;
            outs          <= outs_for(PLL_RST);
            cnt           <= '0;
            retry_count_o <= '0;
            lock_lost_o   <= 1'b0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt >= CNT_W'(PLL_RST_CYCLES - 1)) begin
                        state <= WAIT_LOCK;
                        outs  <= outs_for(WAIT_LOCK);
                        cnt   <= '0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                WAIT_LOCK: begin
                    // Lock takes priority over a timeout landing on the same edge.
                    if (lock_s) begin
                        state <= STABLE;
                        outs  <= outs_for(STABLE);
                        cnt   <= '0;
                    end else if (cnt >= CNT_W'(LOCK_TIMEOUT_CYCLES)) begin
                        if (retry_count_o >= RTY_W'(MAX_RETRIES)) begin
                            state <= FAIL;
                            outs  <= outs_for(FAIL);
                        end else begin
                            retry_count_o <= retry_count_o + 1'b1;
                            state         <= PLL_RST;
                            outs          <= outs_for(PLL_RST);
                            cnt           <= '0;
                        end
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        outs  <= outs_for(WAIT_LOCK);
                        cnt   <= '0;
                    end else if (cnt >= CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state <= RUN;
                        outs  <= outs_for(RUN);
                        cnt   <= '0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        lock_lost_o   <= 1'b1;
                        retry_count_o <= '0;
                        state         <= PLL_RST;
                        outs          <= outs_for(PLL_RST);
                        cnt           <= '0;
                    end
                end
                FAIL: begin
                    state <= FAIL;
                end
                default: begin
                    state <= PLL_RST;
                    outs  <= outs_for(PLL_RST);
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign {pll_reset_o, sys_reset_o, locked_o, fail_o} = outs;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: stimulus queues cycle-tagged
// expected output vectors, a negedge monitor pops and compares them.
module tb_pll_lock_supervisor;

    localparam int SYNC = 2;
    localparam int PRST = 4;
    localparam int STAB = 8;
    localparam int TO   = 50;
    localparam int MAXR = 2;

    localparam int S_RST  = 0;
    localparam int S_WAIT = 1;
    localparam int S_RUN  = 2;
    localparam int S_FAIL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock_i = 1'b0;
    logic       pll_reset_o, sys_reset_o, locked_o, fail_o, lock_lost_o;
    logic [1:0] retry_count_o;
    logic [6:0] act;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int         at;
        logic [6:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];

    pll_lock_supervisor #(
        .SYNC_STAGES        (SYNC),
        .PLL_RST_CYCLES     (PRST),
        .LOCK_STABLE_CYCLES (STAB),
        .LOCK_TIMEOUT_CYCLES(TO),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lock_i       (lock_i),
        .pll_reset_o  (pll_reset_o),
        .sys_reset_o  (sys_reset_o),
        .locked_o     (locked_o),
        .fail_o       (fail_o),
        .lock_lost_o  (lock_lost_o),
        .retry_count_o(retry_count_o)
    );

    assign act = {pll_reset_o, sys_reset_o, locked_o, fail_o, lock_lost_o, retry_count_o};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected {pll_reset, sys_reset, locked, fail, lock_lost, retry_count}.
    function automatic logic [6:0] st(input int s, input logic lost, input logic [1:0] rc);
        logic [3:0] o;
        case (s)
            S_RST:   o = 4'b1100;
            S_WAIT:  o = 4'b0100;
            S_RUN:   o = 4'b0010;
            default: o = 4'b1101;
        endcase
        return {o, lost, rc};
    endfunction

    task automatic expect_at(input int at, input logic [6:0] v, input string name);
        exp_t e;
        e.at   = at;
        e.v    = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset(output int r);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        r = cyc;
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                n_chk++;
                if (act !== sb[i].v) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %b expected %b", sb[i].name, cyc, act, sb[i].v);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, w, c0, w2, w3;

        // Reset values and first PLL reset pulse
        do_reset(r);
        for (int k = 0; k < 4; k++) expect_at(r + k, st(S_RST, 1'b0, 2'd0), "rst_hold");
        for (int k = 4; k < 9; k++) expect_at(r + k, st(S_WAIT, 1'b0, 2'd0), "rst_release");
        w = r + 4;

        // Clean lock 10 cycles into WAIT_LOCK
        wait_until(w + 10);
        lock_i = 1'b1;
        expect_at(w + 13, st(S_WAIT, 1'b0, 2'd0), "clean_stable");
        expect_at(w + 20, st(S_WAIT, 1'b0, 2'd0), "clean_pre_run");
        expect_at(w + 21, st(S_RUN, 1'b0, 2'd0), "clean_run");
        expect_at(w + 30, st(S_RUN, 1'b0, 2'd0), "clean_run_hold");
        wait_until(w + 30);

        // Lock loss in RUN, relock, second loss, reset while STABLE
        c0 = cyc;
        lock_i = 1'b0;
        expect_at(c0 + 2, st(S_RUN, 1'b0, 2'd0), "loss_latency");
        expect_at(c0 + 3, st(S_RST, 1'b1, 2'd0), "loss_reset");
        expect_at(c0 + 6, st(S_RST, 1'b1, 2'd0), "loss_pulse_end");
        expect_at(c0 + 7, st(S_WAIT, 1'b1, 2'd0), "loss_wait");
        wait_until(c0 + 10);
        lock_i = 1'b1;
        expect_at(c0 + 20, st(S_WAIT, 1'b1, 2'd0), "relock_pre_run");
        expect_at(c0 + 21, st(S_RUN, 1'b1, 2'd0), "relock_run");
        wait_until(c0 + 25);
        lock_i = 1'b0;
        expect_at(c0 + 28, st(S_RST, 1'b1, 2'd0), "loss2_reset");
        wait_until(c0 + 30);
        lock_i = 1'b1;
        expect_at(c0 + 33, st(S_WAIT, 1'b1, 2'd0), "stable_before_rst");
        expect_at(c0 + 35, st(S_WAIT, 1'b1, 2'd0), "stable_hold");
        wait_until(c0 + 35);
        rst = 1'b1;
        expect_at(c0 + 36, st(S_RST, 1'b0, 2'd0), "midop_rst");
        tick();
        rst = 1'b0;
        n_chk++;
        if (act !== st(S_RST, 1'b0, 2'd0)) begin
            n_fail++;
            $display("FAIL midop_rst_direct @cyc %0d: got %b", cyc, act);
        end

        // Glitch: 5 high, 3 low, then high
        lock_i = 1'b0;
        do_reset(r);
        w = r + 4;
        for (int k = 0; k < 24; k++) expect_at(w + k, st(S_WAIT, 1'b0, 2'd0), "glitch_hold");
        expect_at(w + 24, st(S_RUN, 1'b0, 2'd0), "glitch_run");
        wait_until(w + 5);
        lock_i = 1'b1;
        wait_until(w + 10);
        lock_i = 1'b0;
        wait_until(w + 13);
        lock_i = 1'b1;
        wait_until(w + 26);

        // Timeout, two retries, then FAIL
        lock_i = 1'b0;
        do_reset(r);
        w  = r + 4;
        w2 = w + 55;
        w3 = w2 + 55;
        expect_at(w + 50, st(S_WAIT, 1'b0, 2'd0), "to1_last_wait");
        expect_at(w + 51, st(S_RST, 1'b0, 2'd1), "retry1_start");
        expect_at(w + 54, st(S_RST, 1'b0, 2'd1), "retry1_end");
        expect_at(w2, st(S_WAIT, 1'b0, 2'd1), "retry1_wait");
        expect_at(w2 + 50, st(S_WAIT, 1'b0, 2'd1), "to2_last_wait");
        expect_at(w2 + 51, st(S_RST, 1'b0, 2'd2), "retry2_start");
        expect_at(w2 + 54, st(S_RST, 1'b0, 2'd2), "retry2_end");
        expect_at(w3, st(S_WAIT, 1'b0, 2'd2), "retry2_wait");
        expect_at(w3 + 50, st(S_WAIT, 1'b0, 2'd2), "to3_last_wait");
        expect_at(w3 + 51, st(S_FAIL, 1'b0, 2'd2), "fail_enter");
        for (int k = 1; k <= 10; k++) expect_at(w3 + 51 + k * 100, st(S_FAIL, 1'b0, 2'd2), "fail_hold");
        wait_until(w3 + 51 + 1002);
        n_chk++;
        if (fail_o !== 1'b1 || pll_reset_o !== 1'b1 || retry_count_o !== 2'd2) begin
            n_fail++;
            $display("FAIL fail_persist_direct @cyc %0d: got %b", cyc, act);
        end

        // Lock arriving on the timeout edge wins
        do_reset(r);
        w = r + 4;
        wait_until(w + 48);
        lock_i = 1'b1;
        expect_at(w + 50, st(S_WAIT, 1'b0, 2'd0), "bnd_wait");
        expect_at(w + 51, st(S_WAIT, 1'b0, 2'd0), "bnd_no_retry");
        expect_at(w + 58, st(S_WAIT, 1'b0, 2'd0), "bnd_pre_run");
        expect_at(w + 59, st(S_RUN, 1'b0, 2'd0), "bnd_run");
        wait_until(w + 62);
        tick();
        n_chk++;
        if (locked_o !== 1'b1 || sys_reset_o !== 1'b0 || retry_count_o !== 2'd0) begin
            n_fail++;
            $display("FAIL bnd_run_direct @cyc %0d: got %b", cyc, act);
        end

        while (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: check at cyc %0d never evaluated, expected %b", sb[0].name, sb[0].at, sb[0].v);
            void'(sb.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
